// File: rtl/bar_ctrl_pkg.sv
// Shared encodings and constants for the bar sweep controller and its bar FSM.
package bar_ctrl_pkg;

  localparam int BAR_LEVEL_MAX = 8;
  localparam int LEVEL_W       = 4;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_UP    = 2'd1,
    ST_DN    = 2'd2,
    ST_PAUSE = 2'd3
  } sweep_state_e;

  function automatic logic [LEVEL_W-1:0] level_step(input logic [LEVEL_W-1:0] lvl,
                                                    input logic              up);
    if (up) begin
      return lvl + LEVEL_W'(1);
    end else begin
      return lvl - LEVEL_W'(1);
    end
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Step-period counter: counts 0..max(div,1)-1 while enabled and flags the last cycle.
module tick_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;
  logic [DIV_W-1:0] last_s;

  // Terminal count; >= makes a div that shrank below the count end the period at once.
  always_comb begin
    if (div == DIV_W'(0)) begin
      last_s = DIV_W'(0);
    end else begin
      last_s = div - DIV_W'(1);
    end
    tick = en && (count_q >= last_s);
  end

  // Next count: clear, wrap on tick, advance, or hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = DIV_W'(0);
    end else if (en && tick) begin
      count_d = DIV_W'(0);
    end else if (en) begin
      count_d = count_q + DIV_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= DIV_W'(0);
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bar_sweep_ctrl.sv
// Drives a 0..LEVEL_MAX bar FSM with single-cycle step strobes, either from
// buttons (manual) or from a bouncing, pausable auto sweep.
module bar_sweep_ctrl
  import bar_ctrl_pkg::*;
#(
  parameter int LEVEL_MAX = BAR_LEVEL_MAX,
  parameter int DIV_W     = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             pause,
  input  logic             btn_up,
  input  logic             btn_dn,
  input  logic [DIV_W-1:0] div,
  output logic             pulse,
  output logic             cnt_up,
  output logic [3:0]       level,
  output logic             at_top,
  output logic             at_bottom
);

  localparam logic [LEVEL_W-1:0] LVL_TOP    = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] LVL_TOP_M1 = LEVEL_W'(LEVEL_MAX - 1);
  localparam logic [LEVEL_W-1:0] LVL_ZERO   = LEVEL_W'(0);
  localparam logic [LEVEL_W-1:0] LVL_ONE    = LEVEL_W'(1);

  sweep_state_e state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic dir_q, dir_d;
  logic pulse_q, pulse_d;
  logic cnt_up_q, cnt_up_d;
  logic at_top_q, at_top_d;
  logic at_bot_q, at_bot_d;
  logic tick_s, pre_en_s, pre_clr_s;
  logic step_up_s, step_dn_s;

  // Prescaler runs only in UP/DN with mode and no pause, so mode and pause beat a tick.
  always_comb begin
    pre_en_s  = mode && !pause && ((state_q == ST_UP) || (state_q == ST_DN));
    pre_clr_s = (state_q == ST_IDLE);
  end

  tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (pre_en_s),
    .clr   (pre_clr_s),
    .div   (div),
    .tick  (tick_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the extra level guards keep the sweep inside 0..LEVEL_MAX.
  always_comb begin
    state_d = state_q;
    if (!mode) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = (level_q < LVL_TOP) ? ST_UP : ST_DN;
        ST_UP: begin
          if (pause)                                 state_d = ST_PAUSE;
          else if (level_q >= LVL_TOP)               state_d = ST_DN;
          else if (tick_s && (level_q == LVL_TOP_M1)) state_d = ST_DN;
          else                                       state_d = ST_UP;
        end
        ST_DN: begin
          if (pause)                               state_d = ST_PAUSE;
          else if (level_q == LVL_ZERO)            state_d = ST_UP;
          else if (tick_s && (level_q == LVL_ONE)) state_d = ST_UP;
          else                                     state_d = ST_DN;
        end
        ST_PAUSE: state_d = pause ? ST_PAUSE : ((dir_q == DIR_UP) ? ST_UP : ST_DN);
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Step decision: buttons only in IDLE with mode low, auto ticks only in UP/DN.
  always_comb begin
    step_up_s = 1'b0;
    step_dn_s = 1'b0;
    if (!mode) begin
      if ((state_q == ST_IDLE) && btn_up && !btn_dn && (level_q < LVL_TOP)) begin
        step_up_s = 1'b1;
      end else if ((state_q == ST_IDLE) && btn_dn && !btn_up && (level_q != LVL_ZERO)) begin
        step_dn_s = 1'b1;
      end else begin
        step_up_s = 1'b0;
      end
    end else if (tick_s && (state_q == ST_UP) && (level_q < LVL_TOP)) begin
      step_up_s = 1'b1;
    end else if (tick_s && (state_q == ST_DN) && (level_q != LVL_ZERO)) begin
      step_dn_s = 1'b1;
    end else begin
      step_up_s = 1'b0;
    end
  end

  // Output/datapath next values; level moves on the same edge that raises pulse.
  always_comb begin
    pulse_d  = step_up_s || step_dn_s;
    cnt_up_d = cnt_up_q;
    level_d  = level_q;
    dir_d    = dir_q;
    if (step_up_s) begin
      cnt_up_d = DIR_UP;
      level_d  = level_step(level_q, DIR_UP);
    end else if (step_dn_s) begin
      cnt_up_d = DIR_DN;
      level_d  = level_step(level_q, DIR_DN);
    end else begin
      level_d  = level_q;
    end
    if (mode && pause && (state_q == ST_UP)) begin
      dir_d = DIR_UP;
    end else if (mode && pause && (state_q == ST_DN)) begin
      dir_d = DIR_DN;
    end else begin
      dir_d = dir_q;
    end
    at_top_d = (level_d == LVL_TOP);
    at_bot_d = (level_d == LVL_ZERO);
  end

  // Registered outputs and saved sweep direction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pulse_q  <= 1'b0;
      cnt_up_q <= DIR_UP;
      level_q  <= LVL_ZERO;
      at_top_q <= 1'b0;
      at_bot_q <= 1'b1;
      dir_q    <= DIR_UP;
    end else begin
      pulse_q  <= pulse_d;
      cnt_up_q <= cnt_up_d;
      level_q  <= level_d;
      at_top_q <= at_top_d;
      at_bot_q <= at_bot_d;
      dir_q    <= dir_d;
    end
  end

  assign pulse     = pulse_q;
  assign cnt_up    = cnt_up_q;
  assign level     = level_q;
  assign at_top    = at_top_q;
  assign at_bottom = at_bot_q;

endmodule

// File: doc/bar_sweep_ctrl.md
BAR_SWEEP_CTRL -- requirements
Module: bar_sweep_ctrl

Interface
REQ-001 SHALL have parameter LEVEL_MAX, default 8, highest bar level of the downstream 9-state bar FSM.
REQ-002 SHALL have parameter DIV_W, default 24, width of the tick divisor.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mode  input  1  0 = manual (button-driven), 1 = auto sweep.
REQ-006 pause  input  1  1 = freeze auto sweep; ignored in manual mode.
REQ-007 btn_up  input  1  single-cycle, pre-debounced step-up request.
REQ-008 btn_dn  input  1  single-cycle, pre-debounced step-down request.
REQ-009 div  input  DIV_W  auto-step period in clk cycles; 0 is treated as 1.
REQ-010 pulse  output  1  registered single-cycle step strobe to the bar FSM.
REQ-011 cnt_up  output  1  registered direction for the bar FSM; valid whenever pulse=1.
REQ-012 level  output  4  committed bar level, 0..LEVEL_MAX.
REQ-013 at_top / at_bottom  output  1 each  level==LEVEL_MAX / level==0.

Function
REQ-014 SHALL implement states IDLE (manual), UP, DN and PAUSE, plus a 1-bit saved direction.
REQ-015 Prescaler: count 0..max(div,1)-1; tick when count reaches max(div,1)-1, then count returns to 0.
REQ-016 Prescaler SHALL count only in UP/DN; it SHALL hold in PAUSE and clear in IDLE.
REQ-017 If div drops below count+1 mid-period, SHALL tick on the next cycle.
REQ-018 pulse SHALL assert for exactly one cycle per step, never two steps per cycle.
REQ-019 level SHALL update on the same edge that asserts pulse: +1 if cnt_up=1, -1 otherwise.
REQ-020 Downstream bar FSM state index therefore equals level one cycle later.
REQ-021 Transitions: any state with mode=0 -> IDLE.
REQ-022 IDLE with mode=1 -> UP if level<LEVEL_MAX, else DN.
REQ-023 UP with pause=1 -> PAUSE (saved dir=up); DN with pause=1 -> PAUSE (saved dir=down).
REQ-024 PAUSE with pause=0 -> saved direction state.
REQ-025 UP on tick: pulse with cnt_up=1; if level==LEVEL_MAX-1, go to DN.
REQ-026 DN on tick: pulse with cnt_up=0; if level==1, go to UP.
REQ-027 Auto mode SHALL bounce and never wrap past LEVEL_MAX or 0; pause has priority over a same-cycle tick.
REQ-028 IDLE, btn_up only, level<LEVEL_MAX: pulse with cnt_up=1 on the next cycle.
REQ-029 IDLE, btn_dn only, level>0: pulse with cnt_up=0 on the next cycle.
REQ-030 IDLE: both buttons together, or a request at the saturated end -> no pulse.
REQ-031 Buttons SHALL be ignored outside IDLE; a mode change SHALL take priority over a same-cycle tick or button.
REQ-032 cnt_up SHALL hold its last value when pulse=0.

Reset
REQ-033 reset=0 SHALL immediately force: state=IDLE, prescaler=0, pulse=0, cnt_up=1, level=0, at_bottom=1, at_top=0, saved dir=up.
REQ-034 Reset assertion mid-sweep SHALL discard any pending tick, so no pulse follows reset release.
REQ-035 First pulse after release SHALL occur no earlier than max(div,1) cycles after entering UP.

Structure
REQ-036 State encodings, LEVEL_MAX and direction constants SHALL reside in shared package bar_ctrl_pkg.
REQ-037 Prescaler SHALL be sub-module tick_prescaler (clk, reset, en, clr, div -> tick).

Verification
REQ-038 Auto sweep: mode=1, div=3 from reset -> pulses every 3 cycles, cnt_up=1 x8, then cnt_up=0 x8; level 0->8->0 repeating; at_top exactly when level=8.
REQ-039 Pause: pause=1 at level 5 mid-period, held 20 cycles -> no pulse, level stays 5; pause=0 -> next pulse after the remaining prescale count.
REQ-040 Manual: mode=0; btn_up x10 -> 8 pulses, level saturates at 8; btn_up and btn_dn same cycle -> no pulse.
REQ-041 div=0 and div=1, auto -> one pulse every cycle, bouncing cleanly at 8 and at 0 with no overshoot.
REQ-042 Reset mid-operation: reset=0 at level 6 in DN -> outputs at reset values within the same cycle; no pulse during or immediately after release.
REQ-043 Scoreboard: a fsm_w_pulse-equivalent model fed pulse/cnt_up SHALL match level each cycle, lagging by one cycle.
